pong_score_controller: RTL and testbench

Sequential score keeper and game sequencer for Pong. It counts points for both players and runs the attract / serve / play / game-over flow. It also feeds the shared seven-segment score renderer: the video counters pick one of four digit positions per pixel, and this block returns the segment lines for that digit, registered. It sits between the ball-miss detection logic and the score-to-video segment circuit.

---
 rtl/pong_score_controller.sv | 185 ++++++++++++++++++
 tb/tb_pong_score_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_score_controller.sv
// Pong score keeper, game sequencer and registered seven-segment digit feed.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module pong_score_controller #(
   parameter int unsigned WIN_SCORE    = 11,
   parameter int unsigned SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       miss_left,
   input  logic       miss_right,
   input  logic       vblank,
   input  logic [1:0] digit_sel,
   input  logic       digit_en,
   output logic [6:0] seg,
   output logic [3:0] left_score,
   output logic [3:0] right_score,
   output logic       attract,
   output logic       serve
);

   typedef enum logic [1:0] {
      S_ATTRACT,
      S_SERVE_WAIT,
      S_PLAY,
      S_GAME_OVER
   } state_t;

   localparam logic [3:0] WIN    = 4'(WIN_SCORE);
   localparam logic [7:0] FRAMES = 8'(SERVE_FRAMES);

   // event bits: 0 start, 1 miss_left, 2 miss_right, 3 vblank
   logic [3:0] r_sync1;
   logic [3:0] r_sync2;
   logic [3:0] r_sync3;
   logic [3:0] w_edge;

   state_t     r_state;
   state_t     w_state_nx;
   logic [3:0] r_left;
   logic [3:0] r_right;
   logic [3:0] w_left_nx;
   logic [3:0] w_right_nx;
   logic [3:0] w_left_inc;
   logic [3:0] w_right_inc;
   logic [7:0] r_frame;
   logic [7:0] w_frame_nx;
   logic       r_serve;
   logic       w_serve_nx;

   logic [6:0] r_seg;
   logic [6:0] w_seg_nx;
   logic [6:0] w_glyph;
   logic [3:0] w_score;
   logic [3:0] w_ones;
   logic [3:0] w_digit;
   logic       w_tens;
   logic       w_blank;

   // two-flop synchroniser plus previous-value flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= {vblank, miss_right, miss_left, start};
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_edge      = r_sync2 & ~r_sync3;
   assign w_left_inc  = r_left + {3'b000, w_edge[2]};
   assign w_right_inc = r_right + {3'b000, w_edge[1]};

   // game state, scores, frame counter and serve pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_ATTRACT;
         r_left  <= '0;
         r_right <= '0;
         r_frame <= '0;
         r_serve <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_left  <= w_left_nx;
         r_right <= w_right_nx;
         r_frame <= w_frame_nx;
         r_serve <= w_serve_nx;
      end
   end

   // sequencer next-state and score updates
   always_comb begin
      w_state_nx = r_state;
      w_left_nx  = r_left;
      w_right_nx = r_right;
      w_frame_nx = r_frame;
      w_serve_nx = 1'b0;
      unique case (r_state)
         S_ATTRACT, S_GAME_OVER: begin
            if (w_edge[0]) begin
               w_left_nx  = '0;
               w_right_nx = '0;
               w_frame_nx = '0;
               w_state_nx = S_SERVE_WAIT;
            end
         end
         S_SERVE_WAIT: begin
            if (w_edge[3]) begin
               if (r_frame + 8'd1 == FRAMES) begin
                  w_serve_nx = 1'b1;
                  w_frame_nx = '0;
                  w_state_nx = S_PLAY;
               end else begin
                  w_frame_nx = r_frame + 8'd1;
               end
            end
         end
         S_PLAY: begin
            if (w_edge[1] || w_edge[2]) begin
               w_left_nx  = w_left_inc;
               w_right_nx = w_right_inc;
               if (w_left_inc == WIN || w_right_inc == WIN) begin
                  w_state_nx = S_GAME_OVER;
               end else begin
                  w_frame_nx = '0;
                  w_state_nx = S_SERVE_WAIT;
               end
            end
         end
         default: w_state_nx = S_ATTRACT;
      endcase
   end

   // split the selected score into tens/ones and pick the digit
   always_comb begin
      w_score = digit_sel[1] ? r_right : r_left;
      w_tens  = (w_score >= 4'd10);
      w_ones  = w_tens ? w_score - 4'd10 : w_score;
      w_digit = digit_sel[0] ? w_ones : {3'b000, w_tens};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      w_blank = ~digit_sel[0] & ~w_tens;
`else
      w_blank = 1'b0;
`endif
   end

   // digit to {g..a} glyph lookup
   always_comb begin
      w_glyph = '0;
      case (w_digit)
         4'd0:    w_glyph = 7'b0111111;
         4'd1:    w_glyph = 7'b0000110;
         4'd2:    w_glyph = 7'b1011011;
         4'd3:    w_glyph = 7'b1001111;
         4'd4:    w_glyph = 7'b1100110;
         4'd5:    w_glyph = 7'b1101101;
         4'd6:    w_glyph = 7'b1111101;
         4'd7:    w_glyph = 7'b0000111;
         4'd8:    w_glyph = 7'b1111111;
         4'd9:    w_glyph = 7'b1101111;
         default: w_glyph = '0;
      endcase
      w_seg_nx = (digit_en && !w_blank) ? w_glyph : '0;
   end

   // register segment lines one cycle behind the digit select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= '0;
      end else begin
         r_seg <= w_seg_nx;
      end
   end

   assign seg         = r_seg;
   assign left_score  = r_left;
   assign right_score = r_right;
   assign serve       = r_serve;
   assign attract     = (r_state == S_ATTRACT) ||
                        (r_state == S_GAME_OVER);

endmodule

// File: tb/tb_pong_score_controller.sv
// Directed scoreboard bench for pong_score_controller.
// Expected values come from a small score model and a glyph table.
module tb_pong_score_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       miss_left;
   logic       miss_right;
   logic       vblank;
   logic [1:0] digit_sel;
   logic       digit_en;
   logic [6:0] seg;
   logic [3:0] left_score;
   logic [3:0] right_score;
   logic       attract;
   logic       serve;

   int n_run   = 0;
   int n_fail  = 0;
   int n_serve = 0;
   int ml      = 0;
   int mr      = 0;

   typedef struct {
      string       tag;
      logic [16:0] exp;
   } sb_t;

   sb_t sb[$];

   localparam logic [6:0] GL [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   pong_score_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .miss_left   (miss_left),
      .miss_right  (miss_right),
      .vblank      (vblank),
      .digit_sel   (digit_sel),
      .digit_en    (digit_en),
      .seg         (seg),
      .left_score  (left_score),
      .right_score (right_score),
      .attract     (attract),
      .serve       (serve)
   );

   always #5 clk = ~clk;

   // count cycles in which serve is seen high
   always @(negedge clk) begin
      if (serve === 1'b1) n_serve++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input string tag, input logic [16:0] e);
      sb_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic chk(input logic [16:0] obs);
      sb_t x;
      n_run++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: got %0h, no expected entry", obs);
         return;
      end
      x = sb.pop_front();
      assert (obs === x.exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h required %0h", x.tag, obs, x.exp);
      end
   endtask

   function automatic logic [16:0] st(input logic a, input logic s,
                                      input int l, input int r);
      return {7'b0, a, s, 4'(l), 4'(r)};
   endfunction

   function automatic logic [16:0] status();
      return {7'b0, attract, serve, left_score, right_score};
   endfunction

   function automatic logic [6:0] exp_seg(input int s, input int ones);
      int t;
      int o;
      t = (s >= 10) ? 1 : 0;
      o = s - 10 * t;
      if (ones != 0) return GL[o];
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      if (t == 0) return 7'b0;
`endif
      return GL[t];
   endfunction

   // which: 0 start, 1 miss_left, 2 miss_right, 3 both misses
   task automatic pulse(input int which);
      start      = (which == 0);
      miss_left  = (which == 1) || (which == 3);
      miss_right = (which == 2) || (which == 3);
      tick(2);
      start      = 1'b0;
      miss_left  = 1'b0;
      miss_right = 1'b0;
      tick(5);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         vblank = 1'b1;
         tick(1);
         vblank = 1'b0;
         tick(2);
      end
      tick(4);
   endtask

   task automatic check_digits();
      for (int d = 0; d < 4; d++) begin
         digit_sel = 2'(d);
         digit_en  = 1'b1;
         push($sformatf("seg_d%0d_%0d_%0d", d, ml, mr),
              {10'b0, exp_seg((d < 2) ? ml : mr, d % 2)});
         tick(1);
         chk({10'b0, seg});
      end
      digit_en = 1'b0;
      push("seg_off", 17'b0);
      tick(1);
      chk({10'b0, seg});
   endtask

   task automatic serve_point(input int which);
      int n0;
      n0 = n_serve;
      frames(60);
      push("serve_pulse", 17'(n0 + 1));
      chk(17'(n_serve));
      pulse(which);
      if (which == 1 || which == 3) mr++;
      if (which == 2 || which == 3) ml++;
      push($sformatf("point_%0d_%0d", ml, mr),
           st((ml == 11) || (mr == 11), 1'b0, ml, mr));
      chk(status());
      check_digits();
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      miss_left  = 1'b0;
      miss_right = 1'b0;
      vblank     = 1'b0;
      digit_sel  = 2'd0;
      digit_en   = 1'b0;
      tick(3);
      push("reset_status", st(1'b1, 1'b0, 0, 0));
      chk(status());
      push("reset_seg", 17'b0);
      chk({10'b0, seg});
      rst_n = 1'b1;
      tick(2);

      pulse(0);
      push("start", st(1'b0, 1'b0, 0, 0));
      chk(status());
      frames(59);
      push("no_serve_59", 17'd0);
      chk(17'(n_serve));
      frames(1);
      push("serve_60_once", 17'd1);
      chk(17'(n_serve));
      push("play_status", st(1'b0, 1'b0, 0, 0));
      chk(status());

      pulse(0);
      push("start_in_play", st(1'b0, 1'b0, 0, 0));
      chk(status());

      pulse(2);
      ml = 1;
      push("miss_right", st(1'b0, 1'b0, 1, 0));
      chk(status());
      pulse(2);
      push("miss_in_wait", st(1'b0, 1'b0, 1, 0));
      chk(status());
      check_digits();

      while (ml < 10) serve_point(2);
      while (mr < 10) serve_point(1);
      serve_point(3);

      pulse(1);
      pulse(2);
      push("miss_game_over", st(1'b1, 1'b0, 11, 11));
      chk(status());
      frames(60);
      push("no_serve_over", 17'(n_serve));
      chk(17'(n_serve));

      pulse(0);
      ml = 0;
      mr = 0;
      push("restart", st(1'b0, 1'b0, 0, 0));
      chk(status());
      repeat (4) serve_point(2);
      repeat (9) serve_point(1);

      frames(10);
      digit_sel = 2'd3;
      digit_en  = 1'b1;
      tick(2);
      push("seg_before_rst", {10'b0, GL[9]});
      chk({10'b0, seg});
      rst_n = 1'b0;
      #1;
      push("async_rst_status", st(1'b1, 1'b0, 0, 0));
      chk(status());
      push("async_rst_seg", 17'b0);
      chk({10'b0, seg});
      tick(2);
      push("rst_held_seg", 17'b0);
      chk({10'b0, seg});
      rst_n    = 1'b1;
      digit_en = 1'b0;
      tick(2);
      ml = 0;
      mr = 0;
      push("after_rst", st(1'b1, 1'b0, 0, 0));
      chk(status());
      pulse(0);
      push("restart_rst", st(1'b0, 1'b0, 0, 0));
      chk(status());
      serve_point(1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
